ntr_resp_ctrl: RTL and testbench

Response controller for the NTR cartridge port. It runs in the system `clk` domain and sits between the `ntr` command decoder and the `ppio` bidirectional pad block. When the decoder flags a complete 8-byte command, this block latches and classifies it, then turns the bus around. It drives response bytes on `ntr_data_out`, one per debounced NTR clock edge, and returns the bus to input when the transfer completes or CS1 is released.

---
 rtl/ntr_resp_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_ntr_resp_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ntr_resp_ctrl.sv
// NTR cartridge response controller: latches decoded commands, classifies them,
// and drives response bytes onto the bus, one per debounced NTR clock edge.
module ntr_resp_ctrl #(
    parameter logic [31:0] CHIP_ID   = 32'hC2FF_01C0,
    parameter logic [15:0] DUMMY_LEN = 16'd8192,
    parameter logic [15:0] DATA_LEN  = 16'd512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ntr_clk_db,
    input  logic        ntr_cs1_db,
    input  logic        cmd_ready,
    input  logic [63:0] cmd,
    input  logic [7:0]  resp_data,
    input  logic        resp_valid,
    output logic        resp_req,
    output logic        ntr_dir,
    output logic [7:0]  ntr_data_out,
    output logic        cmd_strobe,
    output logic [7:0]  cmd_op,
    output logic [55:0] cmd_arg,
    output logic        cmd_unknown,
    output logic        underrun,
    output logic [7:0]  cmd_count
);

    typedef enum logic [2:0] {IDLE, LATCH, DECODE, RESP, DRAIN} state_t;
    typedef enum logic [1:0] {C_NONE, C_DUMMY, C_ID, C_STREAM} cls_t;

    state_t      state;
    cls_t        cls;
    logic [15:0] len;
    logic [15:0] idx;
    logic [15:0] idx_nx;
    logic        rdy_meta, rdy_s;
    logic        clk_cur, clk_prev;
    logic        rise;
    logic [7:0]  stream_byte;
    logic [7:0]  id_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_meta <= 1'b0;
            rdy_s    <= 1'b0;
            clk_cur  <= 1'b0;
            clk_prev <= 1'b0;
        end else begin
            rdy_meta <= cmd_ready;
            rdy_s    <= rdy_meta;
            clk_cur  <= ntr_clk_db;
            clk_prev <= clk_cur;
        end
    end

    assign rise        = clk_cur & ~clk_prev;
    assign idx_nx      = idx + 16'd1;
    assign stream_byte = resp_valid ? resp_data : 8'h00;

    always_comb begin
        id_byte = CHIP_ID[7:0];
        case (idx_nx[1:0])
            2'd1:    id_byte = CHIP_ID[15:8];
            2'd2:    id_byte = CHIP_ID[23:16];
            2'd3:    id_byte = CHIP_ID[31:24];
            default: id_byte = CHIP_ID[7:0];
        endcase
    end

    // Classification is resolved on the LATCH->DECODE edge so that the strobe,
    // the bus turnaround and the first byte are all visible during DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cls          <= C_NONE;
            len          <= 16'd0;
            idx          <= 16'd0;
            resp_req     <= 1'b0;
            ntr_dir      <= 1'b0;
            ntr_data_out <= 8'h00;
            cmd_strobe   <= 1'b0;
            cmd_op       <= 8'h00;
            cmd_arg      <= 56'd0;
            cmd_unknown  <= 1'b0;
            underrun     <= 1'b0;
            cmd_count    <= 8'd0;
        end else begin
            cmd_strobe <= 1'b0;
            resp_req   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rdy_s && !ntr_cs1_db)
                        state <= LATCH;
                end
                LATCH: begin
                    if (ntr_cs1_db) begin
                        state   <= IDLE;
                        ntr_dir <= 1'b0;
                    end else begin
                        cmd_op     <= cmd[63:56];
                        cmd_arg    <= cmd[55:0];
                        cmd_strobe <= 1'b1;
                        cmd_count  <= cmd_count + 8'd1;
                        idx        <= 16'd0;
                        state      <= DECODE;
                        case (cmd[63:56])
                            8'h9F: begin
                                cls          <= C_DUMMY;
                                len          <= DUMMY_LEN;
                                ntr_dir      <= 1'b1;
                                ntr_data_out <= 8'hFF;
                            end
                            8'h90, 8'hB8: begin
                                cls          <= C_ID;
                                len          <= 16'd4;
                                ntr_dir      <= 1'b1;
                                ntr_data_out <= CHIP_ID[7:0];
                            end
                            8'h00, 8'hB7: begin
                                cls          <= C_STREAM;
                                len          <= DATA_LEN;
                                ntr_dir      <= 1'b1;
                                ntr_data_out <= stream_byte;
                                resp_req     <= resp_valid;
                                if (!resp_valid)
                                    underrun <= 1'b1;
                            end
                            default: begin
                                cls         <= C_NONE;
                                cmd_unknown <= 1'b1;
                            end
                        endcase
                    end
                end
                DECODE: begin
                    if (ntr_cs1_db) begin
                        state   <= IDLE;
                        ntr_dir <= 1'b0;
                    end else begin
                        state <= (cls == C_NONE) ? DRAIN : RESP;
                    end
                end
                RESP: begin
                    // CS1 release takes priority over a coincident clock edge.
                    if (ntr_cs1_db) begin
                        state   <= IDLE;
                        ntr_dir <= 1'b0;
                    end else if (rise) begin
                        idx <= idx_nx;
                        if (idx_nx == len) begin
                            ntr_dir <= 1'b0;
                            state   <= DRAIN;
                        end else begin
                            case (cls)
                                C_DUMMY: ntr_data_out <= 8'hFF;
                                C_ID:    ntr_data_out <= id_byte;
                                C_STREAM: begin
                                    ntr_data_out <= stream_byte;
                                    resp_req     <= resp_valid;
                                    if (!resp_valid)
                                        underrun <= 1'b1;
                                end
                                default: ntr_data_out <= ntr_data_out;
                            endcase
                        end
                    end
                end
                DRAIN: begin
                    ntr_dir <= 1'b0;
                    if (ntr_cs1_db && !rdy_s)
                        state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ntr_dir <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntr_resp_ctrl.sv
// Bench for ntr_resp_ctrl: table-driven transfers, hand-built abort/reset
// sequences and randomized transfers checked against a byte-level model.
module tb_ntr_resp_ctrl;

    localparam logic [31:0] CHIP_ID   = 32'hC2FF_01C0;
    localparam logic [15:0] DUMMY_LEN = 16'd6;
    localparam logic [15:0] DATA_LEN  = 16'd4;

    logic        clk, rst_n;
    logic        ntr_clk_db, ntr_cs1_db, cmd_ready;
    logic [63:0] cmd;
    logic [7:0]  resp_data;
    logic        resp_valid;
    logic        resp_req, ntr_dir, cmd_strobe, cmd_unknown, underrun;
    logic [7:0]  ntr_data_out, cmd_op, cmd_count;
    logic [55:0] cmd_arg;

    ntr_resp_ctrl #(.CHIP_ID(CHIP_ID), .DUMMY_LEN(DUMMY_LEN), .DATA_LEN(DATA_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .ntr_clk_db(ntr_clk_db), .ntr_cs1_db(ntr_cs1_db),
        .cmd_ready(cmd_ready), .cmd(cmd), .resp_data(resp_data), .resp_valid(resp_valid),
        .resp_req(resp_req), .ntr_dir(ntr_dir), .ntr_data_out(ntr_data_out),
        .cmd_strobe(cmd_strobe), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .cmd_unknown(cmd_unknown), .underrun(underrun), .cmd_count(cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Data source: a 16-entry ring popped on each observed resp_req.
    logic [7:0] src_mem [16];
    int         pop_cnt = 0;
    always @(negedge clk) begin
        if (resp_req) pop_cnt++;
        resp_data = src_mem[pop_cnt % 16];
    end

    // Model state
    int         mpops = 0;
    bit         m_under = 0, m_unk = 0;
    logic [7:0] m_count = 8'd0;
    logic [7:0] m_data = 8'h00;

    typedef struct {
        logic [7:0]  op;
        int          edges;
        logic [15:0] vmask;
        bit          simul;
        bit          exp_unk;
        bit          exp_under;
    } vec_t;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int op_len(input logic [7:0] op);
        case (op)
            8'h9F:        return int'(DUMMY_LEN);
            8'h90, 8'hB8: return 4;
            8'h00, 8'hB7: return int'(DATA_LEN);
            default:      return 0;
        endcase
    endfunction

    // One transfer: issue command, apply n_edges NTR clock edges (optionally
    // followed by a rise coinciding with CS1 release), then release the bus.
    task automatic xfer(input logic [7:0] op, input int n_edges, input logic [15:0] vmask,
                        input bit simul, input bit rnd);
        logic [7:0]  exp [16];
        logic [55:0] arg;
        int          len, nload;
        bit          known;
        len   = op_len(op);
        known = (len != 0);
        nload = known ? ((n_edges + 1 < len) ? n_edges + 1 : len) : 0;
        for (int i = 0; i < nload; i++) begin
            if (op == 8'h9F) exp[i] = 8'hFF;
            else if (op == 8'h90 || op == 8'hB8) exp[i] = 8'(CHIP_ID >> (8 * (i % 4)));
            else if (vmask[i % 16]) begin exp[i] = src_mem[mpops % 16]; mpops++; end
            else begin exp[i] = 8'h00; m_under = 1; end
        end
        arg = {$urandom, $urandom};
        cmd = {op, arg};
        resp_valid = vmask[0];
        ntr_cs1_db = 1'b0;
        cmd_ready = 1'b1;
        step(3);
        chk("strobe_early", cmd_strobe, 1'b0);
        step(1);
        m_count = m_count + 8'd1;
        if (!known) m_unk = 1;
        chk("strobe", cmd_strobe, 1'b1);
        chk("cmd_op", cmd_op, op);
        chk("cmd_arg", cmd_arg, arg);
        chk("cmd_count", cmd_count, m_count);
        chk("dir_first", ntr_dir, known);
        chk("cmd_unknown", cmd_unknown, m_unk);
        if (known) begin
            chk("byte0", ntr_data_out, exp[0]);
            m_data = exp[0];
        end
        for (int j = 1; j <= n_edges; j++) begin
            resp_valid = vmask[j % 16];
            ntr_clk_db = 1'b1;
            step(2);
            if (known && j < len) begin
                chk("dir_mid", ntr_dir, 1'b1);
                chk("byte", ntr_data_out, exp[j]);
                m_data = exp[j];
            end else begin
                chk("dir_done", ntr_dir, 1'b0);
                chk("byte_hold", ntr_data_out, m_data);
            end
            if (rnd) step($urandom_range(0, 2));
            ntr_clk_db = 1'b0;
            step(rnd ? 2 + $urandom_range(0, 2) : 2);
        end
        if (simul) begin
            ntr_clk_db = 1'b1;
            step(1);
            ntr_cs1_db = 1'b1;
            step(1);
            chk("simul_dir", ntr_dir, 1'b0);
            chk("simul_byte", ntr_data_out, m_data);
            ntr_clk_db = 1'b0;
        end
        ntr_cs1_db = 1'b1;
        cmd_ready = 1'b0;
        step(1);
        chk("release_dir", ntr_dir, 1'b0);
        step(3);
        chk("underrun", underrun, m_under);
        chk("pops", pop_cnt, mpops);
    endtask

    vec_t vecs [8];

    initial begin
        src_mem[0] = 8'h11; src_mem[1] = 8'h22; src_mem[2] = 8'h33; src_mem[3] = 8'h44;
        for (int i = 4; i < 16; i++) src_mem[i] = 8'($urandom);
        resp_data = src_mem[0];
        vecs[0] = '{8'h90, 12, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hB8,  4, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'hB7,  4, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h9F,  2, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h00,  4, 16'hFFFD, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'hB7,  2, 16'hFFFF, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h3C,  3, 16'hFFFF, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{8'h90,  4, 16'hFFFF, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0; ntr_clk_db = 1'b0; ntr_cs1_db = 1'b1; cmd_ready = 1'b0;
        cmd = 64'd0; resp_valid = 1'b0;
        step(2);
        chk("rst_outs", {resp_req, ntr_dir, ntr_data_out, cmd_strobe, cmd_op, cmd_unknown,
                         underrun, cmd_count}, 64'd0);
        chk("rst_arg", cmd_arg, 56'd0);
        rst_n = 1'b1;
        step(2);

        for (int v = 0; v < 8; v++) begin
            xfer(vecs[v].op, vecs[v].edges, vecs[v].vmask, vecs[v].simul, 1'b0);
            chk("vec_unk", cmd_unknown, vecs[v].exp_unk);
            chk("vec_under", underrun, vecs[v].exp_under);
        end

        // Asynchronous reset while a stream command is in DECODE.
        cmd = {8'hB7, 56'h1234}; resp_valid = 1'b1; ntr_cs1_db = 1'b0; cmd_ready = 1'b1;
        step(4);
        chk("pre_rst_req", resp_req, 1'b1);
        chk("pre_rst_dir", ntr_dir, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outs", {resp_req, ntr_dir, ntr_data_out, cmd_strobe, cmd_op, cmd_unknown,
                          underrun, cmd_count}, 64'd0);
        cmd_ready = 1'b0; ntr_cs1_db = 1'b1;
        step(2);
        rst_n = 1'b1;
        m_count = 8'd0; m_under = 0; m_unk = 0; m_data = 8'h00;
        step(2);
        xfer(8'h90, 4, 16'hFFFF, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            logic [7:0] op;
            int         len;
            case ($urandom_range(0, 5))
                0: op = 8'h90;
                1: op = 8'hB8;
                2: op = 8'h00;
                3: op = 8'hB7;
                4: op = 8'h9F;
                default: op = 8'($urandom);
            endcase
            len = op_len(op);
            xfer(op, $urandom_range(1, (len == 0 ? 4 : len) + 2),
                 16'($urandom | $urandom), ($urandom_range(0, 3) == 0), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
